// File: rtl/mem_ctrl.sv
// Responder for the LSQ/fetch memory protocol: serializes each request into byte-wide
// accesses on a synchronous single-port RAM and returns one-cycle ready pulses.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_rollback,
  input  logic                  lsq_ena,
  input  logic [ADDR_WIDTH-1:0] lsq_addr,
  input  logic [DATA_WIDTH-1:0] lsq_wdata,
  input  logic                  lsq_iswrite,
  input  logic [2:0]            lsq_size,
  output logic                  lsq_ready,
  output logic [DATA_WIDTH-1:0] lsq_rdata,
  input  logic                  if_ena,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cyc_q, cyc_d, n_q, n_d;
  logic                  op_if_q, op_if_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d;

  logic                  lp_q, lp_d, lp_wr_q, lp_wr_d;
  logic [ADDR_WIDTH-1:0] lp_addr_q, lp_addr_d;
  logic [DATA_WIDTH-1:0] lp_wdata_q, lp_wdata_d;
  logic [2:0]            lp_size_q, lp_size_d;
  logic                  ip_q, ip_d;
  logic [ADDR_WIDTH-1:0] ip_addr_q, ip_addr_d;

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  lsq_ready_q, lsq_ready_d, if_ready_q, if_ready_d;
  logic [DATA_WIDTH-1:0] lsq_rdata_q, lsq_rdata_d, if_rdata_q, if_rdata_d;

  // The RAM keeps reading the held address while frozen, so the byte that was
  // in flight when ena dropped is saved and replayed on the first enabled cycle.
  logic                  ena_prev_q, ena_prev_d;
  logic [7:0]            din_sav_q, din_sav_d;

  logic                  lsq_v, lsq_w, if_v, start_l, start_i;
  logic [ADDR_WIDTH-1:0] lsq_a, if_a;
  logic [DATA_WIDTH-1:0] lsq_wd;
  logic [2:0]            lsq_sz;
  logic [1:0]            bsel;
  logic [7:0]            din_eff;

  function automatic logic [2:0] nbytes(input logic [2:0] s);
    case (s)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    n_d         = n_q;
    op_if_d     = op_if_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    lp_d        = lp_q;
    lp_wr_d     = lp_wr_q;
    lp_addr_d   = lp_addr_q;
    lp_wdata_d  = lp_wdata_q;
    lp_size_d   = lp_size_q;
    ip_d        = ip_q;
    ip_addr_d   = ip_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    lsq_ready_d = lsq_ready_q;
    lsq_rdata_d = lsq_rdata_q;
    if_ready_d  = if_ready_q;
    if_rdata_d  = if_rdata_q;
    ena_prev_d  = ena;
    din_sav_d   = ena_prev_q ? ram_din : din_sav_q;
    din_eff     = ena_prev_q ? ram_din : din_sav_q;
    bsel        = cyc_q[1:0] - 2'd2;

    lsq_v   = lp_q | lsq_ena;
    lsq_a   = lp_q ? lp_addr_q  : lsq_addr;
    lsq_wd  = lp_q ? lp_wdata_q : lsq_wdata;
    lsq_sz  = lp_q ? lp_size_q  : lsq_size;
    lsq_w   = lp_q ? lp_wr_q    : lsq_iswrite;
    if_v    = (ip_q | if_ena) & ~in_rollback;
    if_a    = ip_q ? ip_addr_q : if_addr;
    start_l = 1'b0;
    start_i = 1'b0;
    if (in_rollback && !lsq_w) lsq_v = 1'b0;

    if (ena) begin
      lsq_ready_d = 1'b0;
      lsq_rdata_d = '0;
      if_ready_d  = 1'b0;
      if_rdata_d  = '0;

      case (state_q)
        IDLE: begin
          ram_addr_d = '0;
          ram_dout_d = '0;
          ram_wr_d   = 1'b0;
          if (lsq_v)     start_l = 1'b1;
          else if (if_v) start_i = 1'b1;
        end
        READ: begin
          if (in_rollback) begin
            state_d    = IDLE;
            ram_addr_d = '0;
          end else begin
            if (cyc_q >= 3'd2) data_d[{bsel, 3'b000} +: 8] = din_eff;
            ram_addr_d = (cyc_q < n_q) ? addr_q + ADDR_WIDTH'(cyc_q) : '0;
            if (cyc_q == n_q + 3'd1) begin
              state_d = IDLE;
              if (op_if_q) begin
                if_ready_d = 1'b1;
                if_rdata_d = data_d;
              end else begin
                lsq_ready_d = 1'b1;
                lsq_rdata_d = data_d;
              end
            end else begin
              cyc_d = cyc_q + 3'd1;
            end
          end
        end
        WRITE: begin
          if (cyc_q < n_q) begin
            ram_addr_d = addr_q + ADDR_WIDTH'(cyc_q);
            ram_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
            cyc_d      = cyc_q + 3'd1;
          end else begin
            state_d     = IDLE;
            ram_wr_d    = 1'b0;
            ram_addr_d  = '0;
            ram_dout_d  = '0;
            lsq_ready_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (start_l) begin
        state_d    = lsq_w ? WRITE : READ;
        addr_d     = lsq_a;
        wdata_d    = lsq_wd;
        n_d        = nbytes(lsq_sz);
        op_if_d    = 1'b0;
        cyc_d      = 3'd1;
        data_d     = '0;
        ram_addr_d = lsq_a;
        ram_wr_d   = lsq_w;
        ram_dout_d = lsq_w ? lsq_wd[7:0] : 8'h00;
      end else if (start_i) begin
        state_d    = READ;
        addr_d     = if_a;
        n_d        = 3'd4;
        op_if_d    = 1'b1;
        cyc_d      = 3'd1;
        data_d     = '0;
        ram_addr_d = if_a;
        ram_wr_d   = 1'b0;
        ram_dout_d = 8'h00;
      end

      lp_d       = lsq_v & ~start_l;
      lp_addr_d  = lsq_a;
      lp_wdata_d = lsq_wd;
      lp_size_d  = lsq_sz;
      lp_wr_d    = lsq_w;
      ip_d       = if_v & ~start_i;
      ip_addr_d  = if_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      n_q         <= '0;
      op_if_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      lp_q        <= 1'b0;
      lp_wr_q     <= 1'b0;
      lp_addr_q   <= '0;
      lp_wdata_q  <= '0;
      lp_size_q   <= '0;
      ip_q        <= 1'b0;
      ip_addr_q   <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      lsq_ready_q <= 1'b0;
      lsq_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      ena_prev_q  <= 1'b1;
      din_sav_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      n_q         <= n_d;
      op_if_q     <= op_if_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      lp_q        <= lp_d;
      lp_wr_q     <= lp_wr_d;
      lp_addr_q   <= lp_addr_d;
      lp_wdata_q  <= lp_wdata_d;
      lp_size_q   <= lp_size_d;
      ip_q        <= ip_d;
      ip_addr_q   <= ip_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      lsq_ready_q <= lsq_ready_d;
      lsq_rdata_q <= lsq_rdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      ena_prev_q  <= ena_prev_d;
      din_sav_q   <= din_sav_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q & ena;
  assign lsq_ready = lsq_ready_q & ena;
  assign if_ready  = if_ready_q & ena;
  assign lsq_rdata = lsq_ready ? lsq_rdata_q : '0;
  assign if_rdata  = if_ready ? if_rdata_q : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, vector table of single LSQ accesses, and
// hand-written conflict / rollback / freeze / reset sequences checked via scoreboards.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, ena, in_rollback;
  logic        lsq_ena, lsq_iswrite, lsq_ready, if_ena, if_ready, ram_wr;
  logic [31:0] lsq_addr, lsq_wdata, lsq_rdata, if_addr, if_rdata, ram_addr;
  logic [2:0]  lsq_size;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
    .lsq_ena(lsq_ena), .lsq_addr(lsq_addr), .lsq_wdata(lsq_wdata),
    .lsq_iswrite(lsq_iswrite), .lsq_size(lsq_size), .lsq_ready(lsq_ready),
    .lsq_rdata(lsq_rdata), .if_ena(if_ena), .if_addr(if_addr),
    .if_ready(if_ready), .if_rdata(if_rdata), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr[11:0]] <= ram_dout;
    ram_din <= mem[ram_addr[11:0]];
  end

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t lsq_q[$];
  exp_t if_q[$];
  int pass_cnt = 0, tot_cnt = 0, wr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tot_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cnt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ram_wr) wr_cnt++;
    if (lsq_ready) begin
      if (lsq_q.size() == 0) chk("lsq_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = lsq_q.pop_front();
        chk("lsq_rdata", lsq_rdata, e.data);
        chk("lsq_ready_cycle", cnt, e.cyc);
      end
    end else if (lsq_rdata != 0) chk("lsq_rdata_idle", lsq_rdata, 32'd0);
    if (if_ready) begin
      if (if_q.size() == 0) chk("if_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e.data);
        chk("if_ready_cycle", cnt, e.cyc);
      end
    end else if (if_rdata != 0) chk("if_rdata_idle", if_rdata, 32'd0);
  end

  // Drive both request ports for one cycle, starting at a negedge.
  task automatic req(input logic l, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [2:0] sz, input logic f, input logic [31:0] fa);
    lsq_ena = l; lsq_addr = a; lsq_wdata = wd; lsq_iswrite = w; lsq_size = sz;
    if_ena = f; if_addr = fa;
    @(negedge clk);
    lsq_ena = 1'b0; if_ena = 1'b0;
  endtask

  task automatic push_l(input logic [31:0] d, input int c);
    exp_t e; e.data = d; e.cyc = c; lsq_q.push_back(e);
  endtask

  task automatic push_i(input logic [31:0] d, input int c);
    exp_t e; e.data = d; e.cyc = c; if_q.push_back(e);
  endtask

  task automatic drain(input int extra);
    int n = 0;
    while ((lsq_q.size() != 0 || if_q.size() != 0) && n < 40) begin
      @(negedge clk); n++;
    end
    if (lsq_q.size() != 0 || if_q.size() != 0) begin
      chk("drain_timeout", 32'(lsq_q.size() + if_q.size()), 32'd0);
      lsq_q.delete(); if_q.delete();
    end
    repeat (extra) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr, wdata, exp;
    logic        wr;
    logic [2:0]  size;
    int          lat;
  } vec_t;
  vec_t vt [12];

  initial begin
    int c, w0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'h44332211;
    mem[12'h021] = 8'h80;
    {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]} = 32'h0A0B0C0D;
    {mem[12'h443], mem[12'h442], mem[12'h441], mem[12'h440]} = 32'h12345678;

    vt[0]  = '{32'h200,      32'hCAFEF00D, 32'h0,        1'b1, 3'd4, 5};
    vt[1]  = '{32'h200,      32'h0,        32'hCAFEF00D, 1'b0, 3'd4, 6};
    vt[2]  = '{32'h100,      32'h0,        32'h44332211, 1'b0, 3'd4, 6};
    vt[3]  = '{32'h20,       32'hFFFFFFAB, 32'h0,        1'b1, 3'd1, 2};
    vt[4]  = '{32'h20,       32'h0,        32'h000080AB, 1'b0, 3'd2, 4};
    vt[5]  = '{32'h21,       32'h0,        32'h00000080, 1'b0, 3'd1, 3};
    vt[6]  = '{32'h300,      32'h12345678, 32'h0,        1'b1, 3'd2, 3};
    vt[7]  = '{32'h300,      32'h0,        32'h00005678, 1'b0, 3'd4, 6};
    vt[8]  = '{32'h200,      32'h0,        32'hCAFEF00D, 1'b0, 3'd0, 6};
    vt[9]  = '{32'hFFFFFFFE, 32'h01020304, 32'h0,        1'b1, 3'd4, 5};
    vt[10] = '{32'hFFFFFFFE, 32'h0,        32'h01020304, 1'b0, 3'd7, 6};
    vt[11] = '{32'h0,        32'h0,        32'h00000102, 1'b0, 3'd2, 4};

    rst = 1'b1; ena = 1'b1; in_rollback = 1'b0;
    lsq_ena = 1'b0; lsq_addr = '0; lsq_wdata = '0; lsq_iswrite = 1'b0; lsq_size = '0;
    if_ena = 1'b0; if_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_ram_addr", ram_addr, 32'h0);
    chk("reset_ready", {30'h0, lsq_ready, if_ready}, 32'h0);
    chk("reset_ram_wr", {31'h0, ram_wr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table of single LSQ accesses.
    for (int i = 0; i < 12; i++) begin
      c = cnt;
      push_l(vt[i].exp, c + vt[i].lat);
      req(1'b1, vt[i].addr, vt[i].wdata, vt[i].wr, vt[i].size, 1'b0, 32'h0);
      drain(1);
    end

    // Single-byte store strobes the RAM exactly once.
    w0 = wr_cnt; c = cnt;
    push_l(32'h0, c + 2);
    req(1'b1, 32'h30, 32'h000000EE, 1'b1, 3'd1, 1'b0, 32'h0);
    drain(1);
    chk("sb_wr_pulses", 32'(wr_cnt - w0), 32'd1);

    // LSQ and fetch in the same cycle: LSQ first, fetch starts in LSQ ready cycle.
    c = cnt;
    push_l(32'h0A0B0C0D, c + 6);
    push_i(32'h12345678, c + 12);
    req(1'b1, 32'h400, 32'h0, 1'b0, 3'd4, 1'b1, 32'h440);
    drain(1);

    // Rollback in cycle 3 of a load: no ready, no writes; next load normal.
    w0 = wr_cnt;
    req(1'b1, 32'h100, 32'h0, 1'b0, 3'd4, 1'b0, 32'h0);
    @(negedge clk);
    in_rollback = 1'b1;
    @(negedge clk);
    in_rollback = 1'b0;
    repeat (8) @(negedge clk);
    chk("rb_load_wr_pulses", 32'(wr_cnt - w0), 32'd0);
    c = cnt;
    push_l(32'h44332211, c + 6);
    req(1'b1, 32'h100, 32'h0, 1'b0, 3'd4, 1'b0, 32'h0);
    drain(1);

    // Rollback during a store with a pending fetch: store completes, fetch dropped.
    w0 = wr_cnt; c = cnt;
    push_l(32'h0, c + 5);
    req(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 3'd4, 1'b1, 32'h440);
    in_rollback = 1'b1;
    @(negedge clk);
    in_rollback = 1'b0;
    drain(8);
    chk("rb_store_wr_pulses", 32'(wr_cnt - w0), 32'd4);
    c = cnt;
    push_l(32'hDEADBEEF, c + 6);
    req(1'b1, 32'h10, 32'h0, 1'b0, 3'd4, 1'b0, 32'h0);
    drain(1);

    // Freeze for 3 cycles in the middle of a fetch.
    c = cnt;
    push_i(32'h12345678, c + 9);
    req(1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1, 32'h440);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    drain(1);

    // Reset in the middle of a load.
    req(1'b1, 32'h100, 32'h0, 1'b0, 3'd4, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ram_addr", ram_addr, 32'h0);
    chk("rst_mid_ready", {31'h0, lsq_ready}, 32'h0);
    repeat (8) @(negedge clk);
    c = cnt;
    push_l(32'h0A0B0C0D, c + 6);
    req(1'b1, 32'h400, 32'h0, 1'b0, 3'd4, 1'b0, 32'h0);
    drain(3);

    chk("queues_empty", 32'(lsq_q.size() + if_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
